// File: rtl/axis_layer_buffer.sv
// axis_layer_buffer
// Frame buffer that sits between two AXI-Stream links and a compute layer.
// One input frame of IN_COUNT words is collected into inBuf, then a start pulse
// is raised. The layer reads inBuf through bufferIn_* and writes its results
// into outBuf through bufferOut_*. When putData is raised, OUT_COUNT words are
// streamed out of outBuf, and the block then returns to collecting input.
//
// Optional feature macro: AXIS_LAYER_BUFFER_TLAST_CHECK_EN
//   When defined, frame_err latches (until rst) on any input tlast that does
//   not line up with the beat-counted frame end. When undefined, s_axis_tlast
//   is ignored and frame_err is tied to 0.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   s_axis_*            input stream (tdata/tvalid/tlast in, tready out)
//   m_axis_*            output stream (tdata/tvalid/tlast out, tready in)
//   bufferIn_adr/data   combinational read port into inBuf
//   bufferOut_adr/data  write port into outBuf, strobed by bufferOut_wr
//   start               one-cycle pulse on entry to COMPUTE
//   putData             layer done; move to DRAIN
//   frame_err           sticky tlast mismatch flag
module axis_layer_buffer #(
    parameter int IN_COUNT  = 784,
    parameter int OUT_COUNT = 10,
    parameter int DATA_SIZE = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_SIZE-1:0]         s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [DATA_SIZE-1:0]         m_axis_tdata,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    input  logic [$clog2(IN_COUNT)-1:0]  bufferIn_adr,
    output logic [DATA_SIZE-1:0]         bufferIn_data,
    input  logic [$clog2(OUT_COUNT)-1:0] bufferOut_adr,
    input  logic [DATA_SIZE-1:0]         bufferOut_data,
    input  logic                         bufferOut_wr,
    output logic                         start,
    input  logic                         putData,
    output logic                         frame_err
);

    localparam int IN_AW  = $clog2(IN_COUNT);
    localparam int OUT_AW = $clog2(OUT_COUNT);
    localparam logic [IN_AW-1:0]  IN_LAST  = IN_AW'(IN_COUNT - 1);
    localparam logic [OUT_AW-1:0] OUT_LAST = OUT_AW'(OUT_COUNT - 1);

    typedef enum logic [1:0] {
        StFill,
        StCompute,
        StDrain
    } state_e;

    state_e              state_q, state_d;
    logic [IN_AW-1:0]    fill_cnt_q, fill_cnt_d;
    logic [OUT_AW-1:0]   drain_cnt_q, drain_cnt_d;
    logic                start_q, start_d;
    logic                in_we;
    logic                out_we;

    logic [DATA_SIZE-1:0] in_buf  [IN_COUNT];
    logic [DATA_SIZE-1:0] out_buf [OUT_COUNT];

    // Next-state and stream handshake outputs
    always_comb begin
        state_d       = state_q;
        fill_cnt_d    = fill_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        start_d       = 1'b0;
        in_we         = 1'b0;
        out_we        = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;

        unique case (state_q)
            StFill: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    in_we = 1'b1;
                    if (fill_cnt_q == IN_LAST) begin
                        fill_cnt_d = '0;
                        state_d    = StCompute;
                        start_d    = 1'b1;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                    end
                end
            end
            StCompute: begin
                // Out-of-range addresses are dropped rather than aliased.
                out_we = bufferOut_wr && (int'(bufferOut_adr) < OUT_COUNT);
                if (putData) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (drain_cnt_q == OUT_LAST);
                if (m_axis_tready) begin
                    if (drain_cnt_q == OUT_LAST) begin
                        drain_cnt_d = '0;
                        state_d     = StFill;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StFill;
            fill_cnt_q  <= '0;
            drain_cnt_q <= '0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            start_q     <= start_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IN_COUNT; i++) begin
                in_buf[i] <= '0;
            end
        end else if (in_we) begin
            in_buf[fill_cnt_q] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OUT_COUNT; i++) begin
                out_buf[i] <= '0;
            end
        end else if (out_we) begin
            out_buf[bufferOut_adr] <= bufferOut_data;
        end
    end

    assign start        = start_q;
    assign m_axis_tdata = out_buf[drain_cnt_q];

    // Non-power-of-two depths leave unused address codes; read those as zero.
    assign bufferIn_data = (int'(bufferIn_adr) < IN_COUNT) ? in_buf[bufferIn_adr] : '0;

`ifdef AXIS_LAYER_BUFFER_TLAST_CHECK_EN
    logic frame_err_q;

    // tlast must be high on the final counted beat and low on all others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else if (in_we && (s_axis_tlast != (fill_cnt_q == IN_LAST))) begin
            frame_err_q <= 1'b1;
        end
    end

    assign frame_err = frame_err_q;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
    assign frame_err    = 1'b0;
`endif

endmodule

// File: tb/tb_axis_layer_buffer.sv
// Self-checking bench for axis_layer_buffer (IN_COUNT=4, OUT_COUNT=3, DATA_SIZE=8).
// A frame-level reference model (input words, output words, error flag) is kept
// in arrays; expected stream beats and buffer reads come from that model.
module tb_axis_layer_buffer;

    localparam int IN_COUNT  = 4;
    localparam int OUT_COUNT = 3;
    localparam int DATA_SIZE = 8;

`ifdef AXIS_LAYER_BUFFER_TLAST_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic [DATA_SIZE-1:0] s_axis_tdata;
    logic                 s_axis_tvalid;
    logic                 s_axis_tlast;
    logic                 s_axis_tready;
    logic [DATA_SIZE-1:0] m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tlast;
    logic                 m_axis_tready;
    logic [1:0]           bufferIn_adr;
    logic [DATA_SIZE-1:0] bufferIn_data;
    logic [1:0]           bufferOut_adr;
    logic [DATA_SIZE-1:0] bufferOut_data;
    logic                 bufferOut_wr;
    logic                 start;
    logic                 putData;
    logic                 frame_err;

    int errors = 0;
    int checks = 0;

    // Reference model
    logic [7:0] m_in  [IN_COUNT];
    logic [7:0] m_out [OUT_COUNT];
    bit         m_err;

    axis_layer_buffer #(
        .IN_COUNT (IN_COUNT),
        .OUT_COUNT(OUT_COUNT),
        .DATA_SIZE(DATA_SIZE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .bufferIn_adr  (bufferIn_adr),
        .bufferIn_data (bufferIn_data),
        .bufferOut_adr (bufferOut_adr),
        .bufferOut_data(bufferOut_data),
        .bufferOut_wr  (bufferOut_wr),
        .start         (start),
        .putData       (putData),
        .frame_err     (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < IN_COUNT; i++) m_in[i] = 8'h00;
        for (int i = 0; i < OUT_COUNT; i++) m_out[i] = 8'h00;
        m_err = 1'b0;
    endfunction

    task automatic idle_inputs();
        s_axis_tdata   = 8'h00;
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        m_axis_tready  = 1'b0;
        bufferIn_adr   = 2'd0;
        bufferOut_adr  = 2'd0;
        bufferOut_data = 8'h00;
        bufferOut_wr   = 1'b0;
        putData        = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Full frame: fill, compute, drain. directed uses the fixed example values;
    // bad_tlast_beat >= 0 places the only tlast on that beat; abort_drain resets
    // the block on the first drain cycle.
    task automatic run_frame(input bit directed, input int bad_tlast_beat, input bit abort_drain);
        logic [7:0] din [IN_COUNT];
        logic [7:0] wdata;
        logic [1:0] wadr;
        logic       wr;
        logic       vld;
        logic       rdy;
        int         i;
        int         k;
        int         stall;
        int         ncyc;

        for (int j = 0; j < IN_COUNT; j++) begin
            din[j] = directed ? 8'(8'h11 * (j + 1)) : 8'($urandom);
        end

        // Fill
        i = 0;
        for (int c = 0; c < 60 && i < IN_COUNT; c++) begin
            vld            = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
            s_axis_tvalid  = vld;
            s_axis_tdata   = din[i];
            s_axis_tlast   = (bad_tlast_beat >= 0) ? (i == bad_tlast_beat) : (i == IN_COUNT - 1);
            // Writes to outBuf while filling must be ignored.
            bufferOut_wr   = directed ? 1'b1 : 1'($urandom_range(0, 1));
            bufferOut_adr  = 2'd0;
            bufferOut_data = 8'hFF;
            checks++;
            if (s_axis_tready !== 1'b1 || start !== 1'b0 || m_axis_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL fill_state: tready=%b start=%b m_tvalid=%b, required 1/0/0",
                         s_axis_tready, start, m_axis_tvalid);
            end
            @(posedge clk);
            #1;
            if (vld) begin
                if (CHK && (s_axis_tlast != (i == IN_COUNT - 1))) m_err = 1'b1;
                m_in[i] = din[i];
                i++;
            end
        end
        if (i < IN_COUNT) begin
            errors++;
            $display("FAIL fill_timeout: accepted=%0d beats, required %0d", i, IN_COUNT);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        bufferOut_wr  = 1'b0;

        // First COMPUTE cycle: start pulse, input closed
        checks++;
        if (start !== 1'b1 || s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL start_pulse: start=%b tready=%b m_tvalid=%b, required 1/0/0",
                     start, s_axis_tready, m_axis_tvalid);
        end
        checks++;
        if (frame_err !== m_err) begin
            errors++;
            $display("FAIL frame_err_fill: got %b, required %b", frame_err, m_err);
        end
        for (int a = 0; a < IN_COUNT; a++) begin
            bufferIn_adr = 2'(a);
            #1;
            checks++;
            if (bufferIn_data !== m_in[a]) begin
                errors++;
                $display("FAIL in_read[%0d]: got %h, required %h", a, bufferIn_data, m_in[a]);
            end
        end

        // Compute
        ncyc = directed ? 4 : $urandom_range(1, 6);
        for (int c = 0; c < ncyc; c++) begin
            if (directed) begin
                wr    = (c < 3);
                wadr  = 2'(c);
                wdata = 8'(8'hA0 + 8'h11 * c);
            end else begin
                wr    = 1'($urandom_range(0, 1));
                wadr  = 2'($urandom_range(0, 3));
                wdata = 8'($urandom);
            end
            bufferOut_wr   = wr;
            bufferOut_adr  = wadr;
            bufferOut_data = wdata;
            putData        = (c == ncyc - 1);
            s_axis_tvalid  = 1'($urandom_range(0, 1));
            s_axis_tdata   = 8'($urandom);
            @(posedge clk);
            #1;
            if (wr && (wadr < OUT_COUNT)) m_out[wadr] = wdata;
            checks++;
            if (start !== 1'b0 || s_axis_tready !== 1'b0) begin
                errors++;
                $display("FAIL compute_state: start=%b tready=%b, required 0/0", start, s_axis_tready);
            end
            if (c != ncyc - 1) begin
                checks++;
                if (m_axis_tvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL compute_tvalid: got %b, required 0", m_axis_tvalid);
                end
            end
        end
        putData = 1'b0;

        // Drain
        k     = 0;
        stall = 0;
        for (int c = 0; c < 60 && k < OUT_COUNT; c++) begin
            if (directed) begin
                rdy = !(k == 1 && stall < 3);
                if (!rdy) stall++;
            end else begin
                rdy = ($urandom_range(0, 2) != 0);
            end
            m_axis_tready  = rdy;
            bufferOut_wr   = 1'($urandom_range(0, 1));
            bufferOut_adr  = 2'($urandom_range(0, 3));
            bufferOut_data = 8'($urandom);
            s_axis_tvalid  = 1'($urandom_range(0, 1));
            s_axis_tdata   = 8'($urandom);
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== m_out[k] ||
                m_axis_tlast !== (k == OUT_COUNT - 1) || s_axis_tready !== 1'b0) begin
                errors++;
                $display("FAIL drain_beat[%0d]: tvalid=%b tdata=%h tlast=%b tready=%b, required 1/%h/%b/0",
                         k, m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready,
                         m_out[k], (k == OUT_COUNT - 1));
            end
            if (abort_drain) begin
                rst = 1'b1;
                #1;
                checks++;
                if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || start !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_in_drain: tvalid=%b tlast=%b start=%b, required 0/0/0",
                             m_axis_tvalid, m_axis_tlast, start);
                end
                @(posedge clk);
                #1;
                rst = 1'b0;
                model_reset();
                idle_inputs();
                m_axis_tready = 1'b1;
                for (int c2 = 0; c2 < 5; c2++) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
                        errors++;
                        $display("FAIL post_abort: tvalid=%b tready=%b, required 0/1",
                                 m_axis_tvalid, s_axis_tready);
                    end
                end
                m_axis_tready = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (rdy) k++;
        end
        if (k < OUT_COUNT) begin
            errors++;
            $display("FAIL drain_timeout: beats=%0d, required %0d", k, OUT_COUNT);
        end
        idle_inputs();

        // Back in FILL, inBuf untouched by drain-time noise
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL return_fill: tvalid=%b tlast=%b tready=%b, required 0/0/1",
                     m_axis_tvalid, m_axis_tlast, s_axis_tready);
        end
        for (int a = 0; a < IN_COUNT; a++) begin
            bufferIn_adr = 2'(a);
            #1;
            checks++;
            if (bufferIn_data !== m_in[a]) begin
                errors++;
                $display("FAIL in_hold[%0d]: got %h, required %h", a, bufferIn_data, m_in[a]);
            end
        end
        checks++;
        if (frame_err !== m_err) begin
            errors++;
            $display("FAIL frame_err_end: got %b, required %b", frame_err, m_err);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #2;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || start !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: tvalid=%b tlast=%b start=%b err=%b, required 0/0/0/0",
                     m_axis_tvalid, m_axis_tlast, start, frame_err);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (s_axis_tready !== 1'b1 || m_axis_tdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: tready=%b m_tdata=%h, required 1/00", s_axis_tready, m_axis_tdata);
        end
        for (int a = 0; a < IN_COUNT; a++) begin
            bufferIn_adr = 2'(a);
            #1;
            checks++;
            if (bufferIn_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_inbuf[%0d]: got %h, required 00", a, bufferIn_data);
            end
        end
    endtask

    task automatic test_directed_frame();
        run_frame(1'b1, -1, 1'b0);
    endtask

    task automatic test_random_back_to_back();
        for (int n = 0; n < 6; n++) run_frame(1'b0, -1, 1'b0);
    endtask

    task automatic test_reset_mid_fill();
        @(posedge clk);
        #1;
        for (int j = 0; j < 2; j++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int a = 0; a < IN_COUNT; a++) begin
            bufferIn_adr = 2'(a);
            #1;
            checks++;
            if (bufferIn_data !== 8'h00) begin
                errors++;
                $display("FAIL abort_fill_inbuf[%0d]: got %h, required 00", a, bufferIn_data);
            end
        end
        run_frame(1'b0, -1, 1'b0);
    endtask

    task automatic test_reset_in_drain();
        run_frame(1'b0, -1, 1'b1);
        run_frame(1'b0, -1, 1'b0);
    endtask

    task automatic test_tlast_check();
        run_frame(1'b0, 1, 1'b0);
        run_frame(1'b0, -1, 1'b0);
        checks++;
        if (frame_err !== CHK) begin
            errors++;
            $display("FAIL frame_err_sticky: got %b, required %b", frame_err, CHK);
        end
        do_reset();
        #1;
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_clear: got %b, required 0", frame_err);
        end
    endtask

    initial begin
        test_reset();
        test_directed_frame();
        test_random_back_to_back();
        test_reset_mid_fill();
        test_reset_in_drain();
        test_tlast_check();
        run_frame(1'b0, -1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
